// File: rtl/seven_segment_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared constants and types for the 4-digit seven-segment scan driver.
//   NUM_DIGITS  : number of multiplexed digits on the board
//   SEG_OFF     : all segments and DP dark (active-low)
//   ANODES_OFF  : all anodes disabled (active-low)
//   SEG_BLANK   : g..a dark, used for leading-zero blanking
//   SEG_TABLE   : hex nibble -> active-low g..a pattern
//   scan_state_t: scan FSM encoding
//   snapshot_t  : per-frame copy of the display inputs
// -----------------------------------------------------------------------------
package seven_seg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic [3:0] ANODES_OFF = 4'hF;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;

  // Index is the nibble value; bit 0 is segment a, bit 6 is segment g.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dots;
    logic                    blank_lz;
  } snapshot_t;

endpackage

// File: rtl/seven_segment_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seven_segment_scan_driver_if
// Display-side signal bundle between the bus interface registers and the
// scan driver.
//   DIGIT_IN   : 16-bit display word, [3:0] = digit 0 (rightmost)
//   DOT_IN     : decimal point enables, bit k = digit k, 1 = lit
//   BLANK_LZ   : 1 = leading-zero blanking enabled
//   SEG_SELECT : anode enables, active-low, bit k = digit k
//   HEX_OUT    : segments, active-low, [6:0] = g..a, [7] = DP
// master: the register block driving the display word
// slave : the scan driver consuming it and driving the board pins
// -----------------------------------------------------------------------------
interface seven_segment_scan_driver_if;
  import seven_seg_pkg::*;

  logic [4*NUM_DIGITS-1:0] DIGIT_IN;
  logic [NUM_DIGITS-1:0]   DOT_IN;
  logic                    BLANK_LZ;
  logic [NUM_DIGITS-1:0]   SEG_SELECT;
  logic [7:0]              HEX_OUT;

  modport master (
    output DIGIT_IN, DOT_IN, BLANK_LZ,
    input  SEG_SELECT, HEX_OUT
  );

  modport slave (
    input  DIGIT_IN, DOT_IN, BLANK_LZ,
    output SEG_SELECT, HEX_OUT
  );

endinterface

// File: rtl/seven_segment_scan_driver_decoder.sv
// -----------------------------------------------------------------------------
// seven_seg_decoder
// Purely combinational nibble -> active-low segment pattern.
//   nibble  : hex value to show
//   dot     : 1 = decimal point lit
//   blank   : 1 = force g..a dark (DP still follows 'dot')
//   pattern : [6:0] = g..a, [7] = DP, all active-low
// -----------------------------------------------------------------------------
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dot,
  input  logic       blank,
  output logic [7:0] pattern
);

  assign pattern[7]   = ~dot;
  assign pattern[6:0] = blank ? SEG_BLANK : SEG_TABLE[nibble];

endmodule

// File: rtl/seven_segment_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_segment_scan_driver
// Time-multiplexes a 16-bit hex word onto a 4-digit common-anode display.
// Inputs are snapshotted once per frame so a frame never mixes two words.
// Each digit slot starts with GUARD_CYCLES of all-anodes-off to avoid ghosting.
//   CLK   : system clock
//   RESET : synchronous, active-high reset
//   disp  : slave side of the display bundle (DIGIT_IN, DOT_IN, BLANK_LZ in;
//           SEG_SELECT, HEX_OUT out, both registered)
// -----------------------------------------------------------------------------
module seven_segment_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int DIV_WIDTH    = 17,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                        CLK,
  input  logic                        RESET,
  seven_segment_scan_driver_if.slave  disp
);

  localparam logic [DIV_WIDTH-1:0] DIV_LAST   = DIV_WIDTH'(REFRESH_DIV - 1);
  localparam bit                   HAS_GUARD  = (GUARD_CYCLES > 0);
  localparam logic [DIV_WIDTH-1:0] GUARD_LAST = HAS_GUARD ? DIV_WIDTH'(GUARD_CYCLES - 1) : '0;
  localparam logic [1:0]           IDX_LAST   = 2'(NUM_DIGITS - 1);

  logic [DIV_WIDTH-1:0] prescaler;
  logic                 tick;
  scan_state_t          state, state_next;
  logic [1:0]           idx, idx_next;
  snapshot_t            snap, snap_next, live;
  logic [3:0]           sel_q, sel_next;
  logic [7:0]           hex_q, hex_next;
  logic [3:0]           dec_nibble;
  logic                 dec_dot;
  logic                 dec_blank;
  logic [7:0]           dec_pattern;

  assign tick = (prescaler == DIV_LAST);

  assign live.digits   = disp.DIGIT_IN;
  assign live.dots     = disp.DOT_IN;
  assign live.blank_lz = disp.BLANK_LZ;

  // Prescaler free-runs from reset; its wrap edge is the slot tick.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + DIV_WIDTH'(1);
    end
  end

  // Scan FSM: the snapshot is reloaded only when a frame starts at digit 0.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    snap_next  = snap;
    if (tick) begin
      unique case (state)
        IDLE: begin
          snap_next  = live;
          idx_next   = '0;
          state_next = SCAN;
        end
        SCAN: begin
          if (idx == IDX_LAST) begin
            snap_next = live;
            idx_next  = '0;
          end else begin
            idx_next = idx + 2'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Decode from the next-slot values so the pattern is registered on the tick
  // edge itself; a digit is blank when it and every higher nibble are zero.
  assign dec_nibble = snap_next.digits[{idx_next, 2'b00} +: 4];
  assign dec_dot    = snap_next.dots[idx_next];
  assign dec_blank  = snap_next.blank_lz && (idx_next != 2'd0) &&
                      ((snap_next.digits >> {idx_next, 2'b00}) == '0);

  seven_seg_decoder u_decoder (
    .nibble  (dec_nibble),
    .dot     (dec_dot),
    .blank   (dec_blank),
    .pattern (dec_pattern)
  );

  // Anodes go dark at the tick and light once the guard window has elapsed.
  always_comb begin
    hex_next = hex_q;
    sel_next = sel_q;
    if (tick) begin
      hex_next = dec_pattern;
      sel_next = HAS_GUARD ? ANODES_OFF : ~(4'b0001 << idx_next);
    end else if (HAS_GUARD && (state == SCAN) && (prescaler == GUARD_LAST)) begin
      sel_next = ~(4'b0001 << idx);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      idx   <= '0;
      snap  <= '0;
      hex_q <= SEG_OFF;
      sel_q <= ANODES_OFF;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      snap  <= snap_next;
      hex_q <= hex_next;
      sel_q <= sel_next;
    end
  end

  assign disp.HEX_OUT    = hex_q;
  assign disp.SEG_SELECT = sel_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_scan_driver
// Self-checking bench for seven_segment_scan_driver with REFRESH_DIV=4 and
// GUARD_CYCLES=1. Each applied display word pushes the four expected slot
// results of the frame that will sample it; slots are popped and compared as
// the DUT scans them.
// -----------------------------------------------------------------------------
module tb_seven_segment_scan_driver;

  typedef struct {
    int         idx;
    logic [7:0] hex;
    logic [3:0] sel;
  } slot_exp_t;

  logic CLK;
  logic RESET;
  int   checks;
  int   errors;
  slot_exp_t sb [$];

  seven_segment_scan_driver_if disp_if ();

  seven_segment_scan_driver #(
    .REFRESH_DIV  (4),
    .DIV_WIDTH    (3),
    .GUARD_CYCLES (1)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .disp  (disp_if)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference segment codes, active-low g..a.
  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [7:0] ref_pattern(input logic [15:0] d, input logic [3:0] dots,
                                             input logic blz, input int k);
    logic [15:0] upper;
    logic        blank;
    upper = d >> (4 * k);
    blank = blz && (k != 0) && (upper == 16'h0);
    return {~dots[k], blank ? 7'h7F : ref_seg(upper[3:0])};
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %02h expected %02h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  // Drive a display word and queue the four slots of the frame that samples it.
  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dots, input logic blz);
    slot_exp_t e;
    disp_if.DIGIT_IN = d;
    disp_if.DOT_IN   = dots;
    disp_if.BLANK_LZ = blz;
    for (int k = 0; k < 4; k++) begin
      e.idx = k;
      e.hex = ref_pattern(d, dots, blz, k);
      e.sel = ~(4'b0001 << k);
      sb.push_back(e);
    end
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      checkOutput("idle_hex", disp_if.HEX_OUT, 8'hFF);
      checkOutput("idle_sel", {4'h0, disp_if.SEG_SELECT}, 8'h0F);
    end
  endtask

  task automatic check_slot();
    slot_exp_t e;
    checkOutput("sb_nonempty", {7'h0, sb.size() != 0}, 8'h01);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    step();
    checkOutput($sformatf("d%0d_guard_hex", e.idx), disp_if.HEX_OUT, e.hex);
    checkOutput($sformatf("d%0d_guard_sel", e.idx), {4'h0, disp_if.SEG_SELECT}, 8'h0F);
    for (int i = 1; i < 4; i++) begin
      step();
      checkOutput($sformatf("d%0d_hex", e.idx), disp_if.HEX_OUT, e.hex);
      checkOutput($sformatf("d%0d_sel", e.idx), {4'h0, disp_if.SEG_SELECT}, {4'h0, e.sel});
    end
  endtask

  initial begin
    slot_exp_t e;
    checks = 0;
    errors = 0;
    RESET  = 1'b1;

    // Reset held 3 cycles, then 4 dark cycles before the first tick.
    applyStimulus(16'h1234, 4'b0000, 1'b0);
    repeat (3) step();
    checkOutput("reset_hex", disp_if.HEX_OUT, 8'hFF);
    checkOutput("reset_sel", {4'h0, disp_if.SEG_SELECT}, 8'h0F);
    RESET = 1'b0;
    check_idle(3);
    repeat (4) check_slot();

    // Steady scan repeats frame after frame.
    applyStimulus(16'h1234, 4'b0000, 1'b0);
    repeat (4) check_slot();

    // Mid-frame change only shows from the next frame.
    applyStimulus(16'h1234, 4'b0000, 1'b0);
    repeat (2) check_slot();
    applyStimulus(16'hABCD, 4'b0000, 1'b0);
    repeat (6) check_slot();

    // Leading-zero blanking, including a blank digit with its DP lit.
    applyStimulus(16'h0050, 4'b0000, 1'b1);
    repeat (4) check_slot();
    applyStimulus(16'h0000, 4'b1000, 1'b1);
    repeat (4) check_slot();

    // Decimal point on one digit only.
    applyStimulus(16'h8888, 4'b0010, 1'b0);
    repeat (4) check_slot();

    // Reset pulse inside the digit-2 slot aborts the frame.
    applyStimulus(16'h1234, 4'b0000, 1'b0);
    repeat (2) check_slot();
    e = sb.pop_front();
    step();
    checkOutput("abort_d2_hex", disp_if.HEX_OUT, e.hex);
    checkOutput("abort_d2_sel", {4'h0, disp_if.SEG_SELECT}, 8'h0F);
    RESET = 1'b1;
    step();
    checkOutput("midreset_hex", disp_if.HEX_OUT, 8'hFF);
    checkOutput("midreset_sel", {4'h0, disp_if.SEG_SELECT}, 8'h0F);
    RESET = 1'b0;
    sb.delete();
    applyStimulus(16'h1234, 4'b0000, 1'b0);
    check_idle(3);
    repeat (4) check_slot();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
